hid_link_tx: RTL



---
 rtl/hid_link_pkg.sv | 20 ++
 rtl/hid_half_tick.sv | 39 +++
 rtl/hid_link_tx.sv | 116 +++++++++++
 3 files changed

// File: rtl/hid_link_pkg.sv
// Shared definitions for the 3-wire HID serial link (transmitter and receiver).
package hid_link_pkg;

  localparam int unsigned HID_DATA_W_DEF  = 16;
  localparam int unsigned HID_CLK_DIV_DEF = 25;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    STROBE,
    GAP
  } hid_state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hid_half_tick.sv
// Link half-period divider: pulses tick_o on the last of CLK_DIV enabled cycles.
module hid_half_tick
  import hid_link_pkg::*;
#(
  parameter int unsigned CLK_DIV = HID_CLK_DIV_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned    DW   = cnt_w(CLK_DIV);
  localparam logic [DW-1:0]  LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hid_link_tx.sv
// HID link transmitter: shifts parallel words out MSB first on dat/clk,
// then pulses str so the receiver latches the word. Lines are active-low.
module hid_link_tx
  import hid_link_pkg::*;
#(
  parameter int unsigned DATA_W  = HID_DATA_W_DEF,
  parameter int unsigned CLK_DIV = HID_CLK_DIV_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              hid_dat_n,
  output logic              hid_clk_n,
  output logic              hid_str_n
);

  localparam int unsigned   BW       = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  hid_state_e        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              in_ready_q, busy_q, frame_done_q, frame_done_d;
  logic              dat_n_q, clk_n_q, str_n_q;
  logic              dat_d, clk_d, str_d;
  logic              tick, accept;

  assign accept = in_valid && in_ready_q;

  hid_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clk_i   (sys_clk),
    .rst_n_i (sys_rst_n),
    .clear_i (state_q == IDLE),
    .en_i    (state_q != IDLE),
    .tick_o  (tick)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shift_d = in_data;
          bit_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: if (tick) state_d = HIGH;
      HIGH: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            state_d = STROBE;
          end else begin
            shift_d = shift_q << 1;
            bit_d   = bit_q + 1'b1;
            state_d = SETUP;
          end
        end
      end
      STROBE: if (tick) state_d = GAP;
      GAP: begin
        if (tick) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line levels are decoded from the next state so every output is a flop.
    dat_d = ((state_d == SETUP) || (state_d == HIGH)) && shift_d[DATA_W-1];
    clk_d = (state_d == HIGH);
    str_d = (state_d == STROBE);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_q        <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      dat_n_q      <= 1'b1;
      clk_n_q      <= 1'b1;
      str_n_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      in_ready_q   <= (state_d == IDLE);
      busy_q       <= (state_d != IDLE);
      frame_done_q <= frame_done_d;
      dat_n_q      <= ~dat_d;
      clk_n_q      <= ~clk_d;
      str_n_q      <= ~str_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign hid_dat_n  = dat_n_q;
  assign hid_clk_n  = clk_n_q;
  assign hid_str_n  = str_n_q;

endmodule
